// File: rtl/ara_pkg.sv
// Shared Ara types: vector element word plus the broadcast-sequencer state and element-width encodings.
package ara_pkg;

    localparam int unsigned ELEN = 64;

    typedef logic [ELEN-1:0] elen_t;

    // Element width code carried on cmd_eew_i
    typedef enum logic [1:0] {
        EEW8  = 2'd0,
        EEW16 = 2'd1,
        EEW32 = 2'd2,
        EEW64 = 2'd3
    } bc_eew_e;

    typedef enum logic [1:0] {
        BC_IDLE  = 2'd0,
        BC_ISSUE = 2'd1,
        BC_DRAIN = 2'd2,
        BC_DONE  = 2'd3
    } bc_seq_state_e;

endpackage

// File: rtl/bc_bcast_seq.sv
// Broadcast sequencer: injects a command's worth of source words into the lane chain,
// bounding in-flight words and waiting for the chain to drain before signalling completion.
module bc_bcast_seq
    import ara_pkg::*;
#(
    parameter int unsigned NrLanes     = 4,
    parameter int unsigned MaxInflight = 2 * NrLanes,
    localparam int unsigned InflW      = $clog2(MaxInflight + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [15:0]      cmd_vl_i,
    input  logic [1:0]       cmd_eew_i,
    input  logic             src_valid_i,
    output logic             src_ready_o,
    input  elen_t            src_data_i,
    output logic             bc_valid_o,
    input  logic             bc_ready_i,
    output elen_t            bc_data_o,
    input  logic             tail_retire_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [InflW-1:0] inflight_o,
    output logic             err_o
);

    localparam int unsigned RemW   = 17;
    localparam int unsigned BytesW = 20;

    bc_seq_state_e    state_q, state_d;
    logic [RemW-1:0]  rem_q, rem_d;
    logic [InflW-1:0] infl_q, infl_d;
    logic             err_q, busy_q, done_q, cmd_ready_q;

    logic [BytesW-1:0] bytes_c;
    logic [RemW-1:0]   rem_cmd_c;
    logic              inject_c, xfer_c, retire_c, err_set_c;

    // Command length in 64-bit words, rounded up
    assign bytes_c   = BytesW'(cmd_vl_i) << cmd_eew_i;
    assign rem_cmd_c = RemW'((bytes_c + BytesW'(7)) >> 3);

    assign inject_c = (state_q == BC_ISSUE) && (rem_q != '0)
                   && (infl_q < InflW'(MaxInflight)) && !abort_i;

    assign bc_valid_o  = inject_c && src_valid_i;
    assign src_ready_o = inject_c && bc_ready_i;
    assign bc_data_o   = src_data_i;

    assign xfer_c = bc_valid_o && bc_ready_i;

    // A retire with nothing in the chain is only legal if a word enters in the same cycle
    assign retire_c  = tail_retire_i && ((infl_q != '0) || xfer_c);
    assign err_set_c = tail_retire_i && (infl_q == '0) && !xfer_c;

    always_comb begin
        infl_d = infl_q;
        if (xfer_c && !retire_c) begin
            infl_d = infl_q + InflW'(1);
        end else if (!xfer_c && retire_c) begin
            infl_d = infl_q - InflW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = xfer_c ? rem_q - RemW'(1) : rem_q;
        unique case (state_q)
            BC_IDLE: begin
                if (cmd_valid_i) begin
                    rem_d   = rem_cmd_c;
                    state_d = (rem_cmd_c == '0) ? BC_DONE : BC_ISSUE;
                end
            end
            BC_ISSUE: begin
                if (abort_i) begin
                    rem_d   = '0;
                    state_d = BC_DRAIN;
                end else if (rem_d == '0) begin
                    state_d = BC_DRAIN;
                end
            end
            BC_DRAIN: begin
                if (infl_d == '0) begin
                    state_d = BC_DONE;
                end
            end
            BC_DONE: begin
                state_d = BC_IDLE;
            end
            default: begin
                state_d = BC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= BC_IDLE;
            rem_q       <= '0;
            infl_q      <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            infl_q      <= infl_d;
            err_q       <= err_q | err_set_c;
            busy_q      <= (state_d != BC_IDLE);
            done_q      <= (state_d == BC_DONE);
            cmd_ready_q <= (state_d == BC_IDLE);
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign inflight_o  = infl_q;
    assign err_o       = err_q;

endmodule

// File: doc/bc_bcast_seq.md
BC_BCAST_SEQ -- requirements
Module: bc_bcast_seq

Interface
REQ-001 SHALL have parameter NrLanes, default 4: number of lanes in the broadcast chain.
REQ-002 SHALL have parameter MaxInflight, default 2*NrLanes: maximum words inside the chain, equal to two slots per lane queue.
REQ-003 SHALL have clk_i, input, 1 bit: the clock; all state updates on its rising edge.
REQ-004 SHALL have rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have cmd_valid_i / cmd_ready_o, input/output, 1 bit each: broadcast command handshake.
REQ-006 SHALL have cmd_vl_i, input, 16 bits: element count.
REQ-007 SHALL have cmd_eew_i, input, 2 bits: element width (0=8, 1=16, 2=32, 3=64 bit).
REQ-008 SHALL have src_valid_i / src_ready_o, input/output, 1 bit each: source word stream handshake.
REQ-009 SHALL have src_data_i, input, elen_t (64 bits): source word.
REQ-010 SHALL have bc_valid_o / bc_ready_i, output/input, 1 bit each: injection handshake into the lane 0 queue.
REQ-011 SHALL have bc_data_o, output, elen_t: injected word.
REQ-012 SHALL have tail_retire_i, input, 1 bit: one word left the last lane's queue this cycle.
REQ-013 SHALL have abort_i, input, 1 bit: stop injecting further words.
REQ-014 SHALL have busy_o, output, 1 bit: a command is in progress.
REQ-015 SHALL have done_o, output, 1 bit: single-cycle completion pulse.
REQ-016 SHALL have inflight_o, output, clog2(MaxInflight+1) bits: current in-flight count.
REQ-017 SHALL have err_o, output, 1 bit: sticky protocol error flag.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-019 SHALL assert cmd_ready_o only in IDLE; a command is accepted on cmd_valid_i && cmd_ready_o.
REQ-020 On acceptance, SHALL set remaining = ceil(cmd_vl_i * 2^cmd_eew_i / 8), computed in 17 bits, and enter ISSUE; if the result is 0, SHALL enter DONE instead.
REQ-021 SHALL define inject = state==ISSUE && remaining!=0 && inflight<MaxInflight && !abort_i.
REQ-022 SHALL drive bc_valid_o = inject && src_valid_i and src_ready_o = inject && bc_ready_i, i.e. combinational pass-through with zero latency.
REQ-023 SHALL drive bc_data_o = src_data_i.
REQ-024 On each transfer (bc_valid_o && bc_ready_i), SHALL decrement remaining and increment inflight.
REQ-025 On tail_retire_i, SHALL decrement inflight; when a transfer and a retire occur in the same cycle, inflight SHALL be unchanged.
REQ-026 When inflight==0 and there is no same-cycle transfer, SHALL ignore tail_retire_i and set err_o.
REQ-027 In ISSUE, SHALL go to DRAIN when remaining reaches 0 (counting a same-cycle last transfer) or when abort_i is 1; abort SHALL clear remaining.
REQ-028 In DRAIN, SHALL go to DONE when the next inflight value is 0.
REQ-029 In DONE, SHALL assert done_o for exactly one cycle, then return to IDLE.
REQ-030 SHALL drive busy_o = state!=IDLE.
REQ-031 SHALL treat abort_i as ignored in IDLE, DRAIN and DONE; in-flight words always drain.
REQ-032 SHALL keep inflight_o equal to inflight at all times; inflight SHALL never exceed MaxInflight or wrap.

Reset
REQ-033 On rst_ni low, SHALL set state=IDLE and remaining=0, inflight=0, err_o=0, done_o=0, busy_o=0; cmd_ready_o=1 while in IDLE.
REQ-034 Reset mid-command SHALL discard all counts with no done_o pulse; chain queues are reset by the same rst_ni.

Structure
REQ-035 SHALL take elen_t from ara_pkg and SHALL add the bc_seq_state_e enum and the eew encoding to ara_pkg.
REQ-036 SHALL be implemented as a single module with no sub-modules.

Verification
REQ-037 vl=16, eew=1 (32 B), source and chain always ready, 4 retires 2 cycles later -> 4 consecutive transfers, done_o 1 cycle after the last retire.
REQ-038 vl=100, eew=3, NrLanes=4, no retires -> exactly 8 transfers then stall with inflight_o=8; each subsequent retire permits one more transfer.
REQ-039 vl=0 -> command accepted, no transfer, done_o the cycle after acceptance.
REQ-040 vl=5, eew=0 -> remaining=1; a transfer and a retire in the same cycle keep inflight unchanged.
REQ-041 abort_i after 3 of 10 transfers -> no further src_ready_o; done_o after the third retire.
REQ-042 tail_retire_i in IDLE -> err_o=1 and sticky until reset; rst_ni low during ISSUE -> IDLE with all counters 0.
